fragment_serializer: RTL and testbench

FRAGMENT_SERIALIZER -- requirements
Module: fragment_serializer

---
 rtl/fragment_serializer.sv | 110 +++++++++++
 tb/tb_fragment_serializer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fragment_serializer.sv
// Quad-to-fragment serializer: accepts 2x2 pixel quads with a coverage mask and
// emits one fragment per covered pixel, lowest mask bit first, to the ROP.
module fragment_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [3:0]  in_mask,
  input  logic [31:0] in_const_color_argb,
  input  logic        in_tex_enable,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_color_argb,
  output logic        out_tex_enable,
  output logic        out_last,
  output logic [31:0] frag_count,
  output logic [31:0] empty_quad_count,
  output logic        busy
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e      state_q;
  logic [31:0] quad_x_q, quad_y_q, color_q;
  logic [31:0] frag_count_q, empty_count_q;
  logic [3:0]  rem_mask_q, rem_mask_d;
  logic        tex_en_q;

  logic [1:0]  sel_idx;
  logic [3:0]  sel_bit;
  logic        single_bit;
  logic        xfer, accept;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_idx = 2'd0;
    sel_bit = 4'b0000;
    if (rem_mask_q[0]) begin
      sel_idx = 2'd0; sel_bit = 4'b0001;
    end else if (rem_mask_q[1]) begin
      sel_idx = 2'd1; sel_bit = 4'b0010;
    end else if (rem_mask_q[2]) begin
      sel_idx = 2'd2; sel_bit = 4'b0100;
    end else if (rem_mask_q[3]) begin
      sel_idx = 2'd3; sel_bit = 4'b1000;
    end
  end

  assign rem_mask_d = rem_mask_q & ~sel_bit;
  assign single_bit = (rem_mask_q != 4'd0) && ((rem_mask_q & (rem_mask_q - 4'd1)) == 4'd0);

  assign out_valid        = (state_q == EMIT);
  assign busy             = (state_q == EMIT);
  assign out_last         = (state_q == EMIT) && single_bit;
  // Ready on the final fragment's transfer cycle lets the next quad load with no bubble.
  assign in_ready         = (state_q == IDLE) || (out_ready && out_last);
  assign out_x            = quad_x_q + {31'd0, sel_idx[0]};
  assign out_y            = quad_y_q + {31'd0, sel_idx[1]};
  assign out_color_argb   = color_q;
  assign out_tex_enable   = tex_en_q;
  assign frag_count       = frag_count_q;
  assign empty_quad_count = empty_count_q;

  assign xfer   = out_valid && out_ready;
  assign accept = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments only; where both the
  // transfer and the accept branch write a register, the later (accept) wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rem_mask_q    <= 4'd0;
      quad_x_q      <= 32'd0;
      quad_y_q      <= 32'd0;
      color_q       <= 32'd0;
      tex_en_q      <= 1'b0;
      frag_count_q  <= 32'd0;
      empty_count_q <= 32'd0;
    end else if (flush) begin
      state_q    <= IDLE;
      rem_mask_q <= 4'd0;
    end else begin
      if (xfer) begin
        rem_mask_q   <= rem_mask_d;
        frag_count_q <= frag_count_q + 32'd1;
        if (rem_mask_d == 4'd0) state_q <= IDLE;
      end
      if (accept) begin
        if (in_mask != 4'd0) begin
          state_q    <= EMIT;
          rem_mask_q <= in_mask;
          quad_x_q   <= in_x;
          quad_y_q   <= in_y;
          color_q    <= in_const_color_argb;
          tex_en_q   <= in_tex_enable;
        end else begin
          state_q       <= IDLE;
          empty_count_q <= empty_count_q + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fragment_serializer.sv
// Bench for fragment_serializer: directed quad table, multi-cycle corner
// sequences, then randomized traffic against a fragment-queue reference model.
module tb_fragment_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0, in_y = '0;
  logic [3:0]  in_mask = '0;
  logic [31:0] in_const_color_argb = '0;
  logic        in_tex_enable = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_x, out_y, out_color_argb;
  logic        out_tex_enable, out_last;
  logic [31:0] frag_count, empty_quad_count;
  logic        busy;

  fragment_serializer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_mask(in_mask),
    .in_const_color_argb(in_const_color_argb), .in_tex_enable(in_tex_enable),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_color_argb(out_color_argb),
    .out_tex_enable(out_tex_enable), .out_last(out_last),
    .frag_count(frag_count), .empty_quad_count(empty_quad_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_frag  = 0;
  logic [31:0] exp_empty = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " out_last"}, 32'(out_last), 32'd0);
    check({tag, " out_x"}, out_x, 32'd0);
    check({tag, " out_y"}, out_y, 32'd0);
    check({tag, " color"}, out_color_argb, 32'd0);
    check({tag, " tex"}, 32'(out_tex_enable), 32'd0);
    check({tag, " frag_count"}, frag_count, 32'd0);
    check({tag, " empty_count"}, empty_quad_count, 32'd0);
  endtask

  task automatic check_frag(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                            input logic el);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_x"}, out_x, ex);
    check({tag, " out_y"}, out_y, ey);
    check({tag, " out_last"}, 32'(out_last), 32'(el));
  endtask

  task automatic offer_quad(input logic [31:0] x, input logic [31:0] y, input logic [3:0] m,
                            input logic [31:0] c, input logic t);
    in_valid = 1'b1; in_x = x; in_y = y; in_mask = m;
    in_const_color_argb = c; in_tex_enable = t;
  endtask

  // Directed quad table: inputs plus the expected fragment sequence.
  typedef struct {
    logic [31:0]      x, y, color;
    logic [3:0]       mask;
    logic             tex;
    int               n;
    logic [3:0][31:0] ex;
    logic [3:0][31:0] ey;
  } vec_t;

  vec_t tbl[7];

  task automatic set_vec(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] m, input logic [31:0] c, input logic t, input int n,
                         input logic [31:0] x0, input logic [31:0] y0,
                         input logic [31:0] x1, input logic [31:0] y1,
                         input logic [31:0] x2, input logic [31:0] y2,
                         input logic [31:0] x3, input logic [31:0] y3);
    tbl[i].x = x; tbl[i].y = y; tbl[i].mask = m; tbl[i].color = c; tbl[i].tex = t;
    tbl[i].n = n;
    tbl[i].ex[0] = x0; tbl[i].ey[0] = y0; tbl[i].ex[1] = x1; tbl[i].ey[1] = y1;
    tbl[i].ex[2] = x2; tbl[i].ey[2] = y2; tbl[i].ex[3] = x3; tbl[i].ey[3] = y3;
  endtask

  // Reference model: the fragments still owed for the current quad.
  typedef struct {
    logic [31:0] x, y, c;
    logic        t;
  } frag_t;
  frag_t q[$];

  initial begin
    set_vec(0, 32'd10, 32'd20, 4'hF, 32'hAABBCCDD, 1'b1, 4,
            32'd10, 32'd20, 32'd11, 32'd20, 32'd10, 32'd21, 32'd11, 32'd21);
    set_vec(1, 32'hFFFFFFFF, 32'd7, 4'h2, 32'h11223344, 1'b0, 1,
            32'd0, 32'd7, 0, 0, 0, 0, 0, 0);
    set_vec(2, 32'd100, 32'd200, 4'h9, 32'h00FF00FF, 1'b1, 2,
            32'd100, 32'd200, 32'd101, 32'd201, 0, 0, 0, 0);
    set_vec(3, 32'd5, 32'hFFFFFFFF, 4'hC, 32'h12345678, 1'b0, 2,
            32'd5, 32'd0, 32'd6, 32'd0, 0, 0, 0, 0);
    set_vec(4, 32'd3, 32'd3, 4'h0, 32'hDEADBEEF, 1'b1, 0,
            0, 0, 0, 0, 0, 0, 0, 0);
    set_vec(5, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h8, 32'hCAFEF00D, 1'b1, 1,
            32'd0, 32'd0, 0, 0, 0, 0, 0, 0);
    set_vec(6, 32'd40, 32'd41, 4'h6, 32'h0BADF00D, 1'b0, 2,
            32'd41, 32'd41, 32'd40, 32'd42, 0, 0, 0, 0);

    // Reset state, during and after reset.
    #2;
    check_reset_outputs("rst_active");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_released");

    // Directed table with out_ready held high.
    foreach (tbl[i]) begin
      @(negedge clk);
      out_ready = 1'b1;
      offer_quad(tbl[i].x, tbl[i].y, tbl[i].mask, tbl[i].color, tbl[i].tex);
      #1;
      check($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      if (tbl[i].mask == 4'h0) exp_empty++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      for (int k = 0; k < tbl[i].n; k++) begin
        check_frag($sformatf("tbl%0d frag%0d", i, k), tbl[i].ex[k], tbl[i].ey[k],
                   k == tbl[i].n - 1);
        check($sformatf("tbl%0d frag%0d color", i, k), out_color_argb, tbl[i].color);
        check($sformatf("tbl%0d frag%0d tex", i, k), 32'(out_tex_enable), 32'(tbl[i].tex));
        @(posedge clk);
        exp_frag++;
        @(negedge clk);
        #1;
      end
      check($sformatf("tbl%0d done out_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("tbl%0d frag_count", i), frag_count, exp_frag);
      check($sformatf("tbl%0d empty_count", i), empty_quad_count, exp_empty);
    end

    // Sparse quad with a 3-cycle stall.
    @(negedge clk);
    out_ready = 1'b0;
    offer_quad(32'd50, 32'd60, 4'hA, 32'h55667788, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_frag($sformatf("stall%0d", k), 32'd51, 32'd60, 1'b0);
      check($sformatf("stall%0d color", k), out_color_argb, 32'h55667788);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_frag("stall release", 32'd51, 32'd60, 1'b0);
    @(negedge clk);
    #1;
    check_frag("stall second", 32'd51, 32'd61, 1'b1);
    check("stall frag_count held", frag_count, exp_frag + 32'd1);
    @(negedge clk);
    exp_frag += 2;
    #1;
    check("stall done out_valid", 32'(out_valid), 32'd0);

    // Back-to-back single-fragment quads with no bubble.
    @(negedge clk);
    offer_quad(32'd1, 32'd9, 4'h1, 32'h1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    offer_quad(32'd2, 32'd9, 4'h1, 32'h2, 1'b1);
    #1;
    check_frag("b2b first", 32'd1, 32'd9, 1'b1);
    check("b2b in_ready on last", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_frag("b2b second", 32'd2, 32'd9, 1'b1);
    check("b2b second color", out_color_argb, 32'h2);
    @(negedge clk);
    exp_frag += 2;
    #1;
    check("b2b done out_valid", 32'(out_valid), 32'd0);
    check("b2b frag_count", frag_count, exp_frag);

    // Flush after the second transfer of a full quad.
    @(negedge clk);
    offer_quad(32'd10, 32'd20, 4'hF, 32'h77, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_frag += 2;
    flush = 1'b1;
    #1;
    check_frag("flush pending", 32'd10, 32'd21, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush busy", 32'(busy), 32'd0);
    check("flush frag_count", frag_count, exp_frag);
    offer_quad(32'd7, 32'd8, 4'h3, 32'h99, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_frag("post-flush first", 32'd7, 32'd8, 1'b0);
    @(negedge clk);
    #1;
    check_frag("post-flush second", 32'd8, 32'd8, 1'b1);
    @(negedge clk);
    exp_frag += 2;
    #1;
    check("post-flush frag_count", frag_count, exp_frag);

    // Asynchronous reset mid-quad.
    offer_quad(32'd1, 32'd2, 4'hF, 32'hFFFF0000, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_frag("pre-reset", 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_midquad");
    @(negedge clk);
    rst = 1'b0;
    exp_frag = 0;
    exp_empty = 0;
    #1;
    check_reset_outputs("rst_midquad_after");

    // Randomized traffic against the fragment-queue model.
    out_ready = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      logic exp_ready;
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_x = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      in_y = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      in_mask = 4'($urandom_range(0, 15));
      in_const_color_argb = $urandom;
      in_tex_enable = 1'($urandom_range(0, 1));
      #1;
      exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
      check("rnd in_ready", 32'(in_ready), 32'(exp_ready));
      check("rnd out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("rnd busy", 32'(busy), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check_frag("rnd frag", q[0].x, q[0].y, q.size() == 1);
        check("rnd color", out_color_argb, q[0].c);
        check("rnd tex", 32'(out_tex_enable), 32'(q[0].t));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_ready && q.size() != 0) begin
          void'(q.pop_front());
          exp_frag++;
        end
        if (in_valid && exp_ready) begin
          if (in_mask == 4'h0) exp_empty++;
          for (int b = 0; b < 4; b++)
            if (in_mask[b])
              q.push_back('{x: in_x + 32'(b % 2), y: in_y + 32'(b / 2),
                            c: in_const_color_argb, t: in_tex_enable});
        end
      end
      @(posedge clk);
      if (it % 50 == 49) begin
        #1;
        check("rnd frag_count", frag_count, exp_frag);
        check("rnd empty_count", empty_quad_count, exp_empty);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
